// File: rtl/decode_pipe.sv
// Decode stage: register file, immediate extension, load-use interlock and ID/EX register.
// Define DECODE_WBYPASS_EN to forward a same-cycle writeback to the operand reads.
module decode_pipe #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int CTRLW = 16,
  localparam int AW   = $clog2(NREG)
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_instr,
  input  logic [XLEN-1:0]  i_pc4,
  input  logic [CTRLW-1:0] i_ctrl,
  input  logic             i_memread,
  input  logic             i_signext,
  input  logic             i_flush,
  input  logic             i_ex_ready,
  input  logic             i_wb_en,
  input  logic [AW-1:0]    i_wb_addr,
  input  logic [XLEN-1:0]  i_wb_data,
  output logic             o_valid,
  output logic [XLEN-1:0]  o_rs_data,
  output logic [XLEN-1:0]  o_rt_data,
  output logic [AW-1:0]    o_rs_addr,
  output logic [AW-1:0]    o_rt_addr,
  output logic [AW-1:0]    o_rd_addr,
  output logic [XLEN-1:0]  o_imm,
  output logic [XLEN-1:0]  o_pc4,
  output logic [CTRLW-1:0] o_ctrl,
  output logic             o_memread,
  output logic             o_cmp_eq,
  output logic [15:0]      o_stall_cnt
);

  logic [AW-1:0]   rs, rt, rd;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] rs_val, rt_val;
  logic [XLEN-1:0] rf [NREG];
  logic            wb_write;
  logic            hazard;
  logic            xfer;
  logic            unused_instr;

  assign rs = i_instr[21 +: AW];
  assign rt = i_instr[16 +: AW];
  assign rd = i_instr[11 +: AW];
  assign unused_instr = ^i_instr;

  assign imm_ext  = {{(XLEN-16){i_signext & i_instr[15]}}, i_instr[15:0]};
  assign wb_write = i_wb_en && (i_wb_addr != '0);

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_write) begin
      rf[i_wb_addr] <= i_wb_data;
    end
  end

  always_comb begin
    rs_val = (rs == '0) ? '0 : rf[rs];
    rt_val = (rt == '0) ? '0 : rf[rt];
`ifdef DECODE_WBYPASS_EN
    if (wb_write && (i_wb_addr == rs)) rs_val = i_wb_data;
    if (wb_write && (i_wb_addr == rt)) rt_val = i_wb_data;
`endif
  end

  assign o_cmp_eq = (rs_val == rt_val);

  // Load in ID/EX whose destination feeds the instruction now in decode.
  assign hazard  = o_valid && o_memread && (o_rt_addr != '0) &&
                   ((o_rt_addr == rs) || (o_rt_addr == rt));
  assign o_ready = i_flush || ((i_ex_ready || !o_valid) && !hazard);
  assign xfer    = i_valid && o_ready && !i_flush;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      o_valid   <= 1'b0;
      o_memread <= 1'b0;
      o_ctrl    <= '0;
      o_rs_data <= '0;
      o_rt_data <= '0;
      o_rs_addr <= '0;
      o_rt_addr <= '0;
      o_rd_addr <= '0;
      o_imm     <= '0;
      o_pc4     <= '0;
    end else if (i_flush) begin
      o_valid   <= 1'b0;
      o_memread <= 1'b0;
      o_ctrl    <= '0;
    end else if (xfer) begin
      o_valid   <= 1'b1;
      o_memread <= i_memread;
      o_ctrl    <= i_ctrl;
      o_rs_data <= rs_val;
      o_rt_data <= rt_val;
      o_rs_addr <= rs;
      o_rt_addr <= rt;
      o_rd_addr <= rd;
      o_imm     <= imm_ext;
      o_pc4     <= i_pc4;
    end else if (i_ex_ready || !o_valid) begin
      o_valid   <= 1'b0;
      o_memread <= 1'b0;
      o_ctrl    <= '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      o_stall_cnt <= '0;
    end else if (i_valid && hazard && !i_flush && (o_stall_cnt != 16'hFFFF)) begin
      o_stall_cnt <= o_stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_decode_pipe.sv
// Randomized scoreboard bench for decode_pipe with a transaction-level reference model.
module tb_decode_pipe;

  logic        clk = 1'b0;
  logic        nrst;
  logic        valid, ready, memread, signext, flush, ex_ready, wb_en;
  logic [31:0] instr, pc4, wb_data;
  logic [15:0] ctrl;
  logic [4:0]  wb_addr;
  logic        o_valid, o_memread, o_cmp_eq;
  logic [31:0] o_rs_data, o_rt_data, o_imm, o_pc4;
  logic [4:0]  o_rs_addr, o_rt_addr, o_rd_addr;
  logic [15:0] o_ctrl, o_stall_cnt;

  always #5 clk = ~clk;

  decode_pipe dut (
    .i_clk(clk), .i_nrst(nrst), .i_valid(valid), .o_ready(ready), .i_instr(instr),
    .i_pc4(pc4), .i_ctrl(ctrl), .i_memread(memread), .i_signext(signext), .i_flush(flush),
    .i_ex_ready(ex_ready), .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .o_valid(o_valid), .o_rs_data(o_rs_data), .o_rt_data(o_rt_data), .o_rs_addr(o_rs_addr),
    .o_rt_addr(o_rt_addr), .o_rd_addr(o_rd_addr), .o_imm(o_imm), .o_pc4(o_pc4),
    .o_ctrl(o_ctrl), .o_memread(o_memread), .o_cmp_eq(o_cmp_eq), .o_stall_cnt(o_stall_cnt)
  );

  typedef struct {
    logic [31:0] rsd, rtd, imm, pc4;
    logic [4:0]  rs, rt, rd;
    logic [15:0] ctrl;
    logic        mr;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mregs [32];
  logic [15:0] mstall;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef DECODE_WBYPASS_EN
    if (wb_en && wb_addr == a) return wb_data;
`endif
    return mregs[a];
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {6'd0, rs, rt, imm};
  endfunction

  // One cycle: drive, check combinational outputs, then advance the model before the edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic mr, input logic se,
                      input logic fl, input logic er, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd);
    logic [4:0] rs, rt;
    logic       empty, haz, rdy;
    exp_t       e;
    @(negedge clk);
    valid = v; instr = ins; memread = mr; signext = se; flush = fl; ex_ready = er;
    wb_en = we; wb_addr = wa; wb_data = wd; pc4 = $urandom; ctrl = 16'($urandom);
    #1;
    rs = ins[25:21];
    rt = ins[20:16];
    empty = (q.size() == 0);
    haz = !empty && q[0].mr && q[0].rt != 5'd0 && (q[0].rt == rs || q[0].rt == rt);
    rdy = fl || ((er || empty) && !haz);
    chk("o_ready", 32'(ready), 32'(rdy));
    chk("o_cmp_eq", 32'(o_cmp_eq), 32'(mread(rs) == mread(rt)));
    chk("o_stall_cnt", 32'(o_stall_cnt), 32'(mstall));
    e.rsd = mread(rs); e.rtd = mread(rt);
    e.imm = se ? 32'($signed(ins[15:0])) : {16'd0, ins[15:0]};
    e.pc4 = pc4; e.rs = rs; e.rt = rt; e.rd = ins[15:11]; e.ctrl = ctrl; e.mr = mr;
    #3;
    if (fl) q.delete();
    else begin
      if (er || empty) q.delete();
      if (v && rdy) q.push_back(e);
    end
    if (v && haz && !fl && mstall != 16'hFFFF) mstall++;
    if (we && wa != 5'd0) mregs[wa] = wd;
  endtask

  task automatic idle();
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    valid = 1'b0; flush = 1'b0; wb_en = 1'b0;
    nrst = 1'b0;
    #1;
    chk("reset o_valid", 32'(o_valid), 32'd0);
    chk("reset o_stall_cnt", 32'(o_stall_cnt), 32'd0);
    chk("reset o_ready", 32'(ready), 32'd1);
    chk("reset o_ctrl", 32'(o_ctrl), 32'd0);
    q.delete();
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    mstall = 16'd0;
    #3 nrst = 1'b1;
  endtask

  // Monitor: compares whatever leaves ID/EX against the oldest expected entry.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #3;
      if (nrst === 1'b1) begin
        chk("o_valid", 32'(o_valid), 32'(q.size() != 0));
        if (o_valid && ex_ready && q.size() != 0) begin
          x = q.pop_front();
          chk("o_rs_data", o_rs_data, x.rsd);
          chk("o_rt_data", o_rt_data, x.rtd);
          chk("o_rs_addr", 32'(o_rs_addr), 32'(x.rs));
          chk("o_rt_addr", 32'(o_rt_addr), 32'(x.rt));
          chk("o_rd_addr", 32'(o_rd_addr), 32'(x.rd));
          chk("o_imm", o_imm, x.imm);
          chk("o_pc4", o_pc4, x.pc4);
          chk("o_ctrl", 32'(o_ctrl), 32'(x.ctrl));
          chk("o_memread", 32'(o_memread), 32'(x.mr));
        end
      end
    end
  end

  initial begin
    nrst = 1'b0; valid = 1'b0; instr = '0; pc4 = '0; ctrl = '0; memread = 1'b0;
    signext = 1'b0; flush = 1'b0; ex_ready = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    mstall = 16'd0;
    do_reset();

    // writeback then read
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 32'h1234);
    step(1'b1, mk(5'd5, 5'd0, 16'h0), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    idle();
    // load-use stall
    step(1'b1, mk(5'd1, 5'd7, 16'h0), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    step(1'b1, mk(5'd7, 5'd2, 16'h0), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    step(1'b1, mk(5'd7, 5'd2, 16'h0), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    idle();
    // flush during hazard
    step(1'b1, mk(5'd1, 5'd7, 16'h0), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    step(1'b1, mk(5'd7, 5'd2, 16'h0), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
    idle();
    // execute backpressure
    step(1'b1, mk(5'd2, 5'd3, 16'h4), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++)
      step(1'b1, mk(5'd4, 5'd5, 16'h6), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    step(1'b1, mk(5'd4, 5'd5, 16'h6), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    idle();
    // same-cycle write, write to r0
    step(1'b1, mk(5'd3, 5'd0, 16'h0), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 32'hAAAA);
    step(1'b1, mk(5'd3, 5'd0, 16'h0), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 32'h5555);
    step(1'b1, mk(5'd0, 5'd0, 16'h0), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    // immediate extension
    step(1'b1, mk(5'd0, 5'd0, 16'h8001), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    step(1'b1, mk(5'd0, 5'd0, 16'h8001), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    idle();
    // reset during a stall
    step(1'b1, mk(5'd1, 5'd7, 16'h0), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    step(1'b1, mk(5'd7, 5'd0, 16'h0), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    do_reset();
    step(1'b1, mk(5'd7, 5'd0, 16'h0), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    idle();

    for (int i = 0; i < 3000; i++) begin
      logic [15:0] imm;
      imm = ($urandom_range(0, 7) == 0) ? 16'h8001 : 16'($urandom);
      if ($urandom_range(0, 499) == 0) do_reset();
      step(1'($urandom_range(0, 9) < 8),
           mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), imm),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
    end
    for (int i = 0; i < 3; i++) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameter XLEN, 32, datapath width of register data, PC+4 and immediate.
REQ-002 Parameter NREG, 32, register count; power of two, 2..32; AW = log2(NREG).
REQ-003 Parameter CTRLW, 16, width of the pass-through control bundle.
REQ-004 i_clk  in  1  clock; i_nrst  in  1  reset, asynchronous, active-low.
REQ-005 i_valid  in  1  instruction from fetch is valid.
REQ-006 o_ready  out  1  decode accepts the fetch instruction this cycle.
REQ-007 i_instr  in  32  instruction word.
REQ-008 i_pc4  in  XLEN  PC+4 of the instruction.
REQ-009 i_ctrl  in  CTRLW  control bundle from the control decoder.
REQ-010 i_memread  in  1  instruction is a load.
REQ-011 i_signext  in  1  sign-extend (1) or zero-extend (0) the immediate.
REQ-012 i_flush  in  1  discard the decode-stage contents.
REQ-013 i_ex_ready  in  1  execute stage accepts the ID/EX register.
REQ-014 i_wb_en, i_wb_addr, i_wb_data  in  1, AW, XLEN  writeback port.
REQ-015 o_valid  out  1  ID/EX register holds a valid instruction.
REQ-016 o_rs_data, o_rt_data  out  XLEN  registered operands.
REQ-017 o_rs_addr, o_rt_addr, o_rd_addr  out  AW  registered fields.
REQ-018 o_imm, o_pc4  out  XLEN  registered extended immediate and PC+4.
REQ-019 o_ctrl, o_memread  out  CTRLW, 1  registered control.
REQ-020 o_cmp_eq  out  1  combinational: the rs read value equals the rt read value, for branch resolution.
REQ-021 o_stall_cnt  out  16  count of load-use stall cycles.

Function
REQ-022 Register fields: rs = i_instr[21+:AW]; rt = i_instr[16+:AW]; rd = i_instr[11+:AW].
REQ-023 Register file: NREG x XLEN; write on posedge when i_wb_en=1 and i_wb_addr!=0; register 0 always reads 0.
REQ-024 Immediate: i_instr[15:0] extended to XLEN, sign or zero per i_signext.
REQ-025 Hazard = o_valid & o_memread & (o_rt_addr!=0) & (o_rt_addr==rs | o_rt_addr==rt).
REQ-026 o_ready = i_flush | ((i_ex_ready | ~o_valid) & ~hazard).
REQ-027 Transfer occurs when i_valid & o_ready & ~i_flush; the ID/EX register loads all fields and o_valid becomes 1 at the next edge, a latency of 1 cycle.
REQ-028 When i_ex_ready=1 or o_valid=0, and no transfer occurs, the next edge sets o_valid=0, i.e. inserts a bubble.
REQ-029 When o_valid=1 and i_ex_ready=0, all ID/EX fields hold.
REQ-030 i_flush=1: the next edge sets o_valid=0 regardless of i_ex_ready; the fetch instruction is dropped; flush has priority over hazard and transfer.
REQ-031 Bubble or flush clears o_valid, o_memread and o_ctrl; data fields are don't-care.
REQ-032 o_stall_cnt increments each cycle in which i_valid & hazard & ~i_flush, and saturates at 0xFFFF.

Reset
REQ-033 i_nrst=0 clears the following immediately: o_valid, all ID/EX fields, o_stall_cnt and all register-file entries; o_ready then equals 1.
REQ-034 Reset mid-stall discards the held instruction; there is no residual hazard after release.

Configuration
REQ-035 DECODE_WBYPASS_EN defined: when i_wb_en=1, i_wb_addr!=0 and i_wb_addr equals rs or rt, that read returns i_wb_data in the same cycle; this applies to o_cmp_eq and to the ID/EX capture.
REQ-036 DECODE_WBYPASS_EN undefined: reads return the pre-edge register contents; the same-cycle write becomes visible the next cycle.

Verification
REQ-037 Write r5=0x1234 via writeback, then decode rs=5 rt=0 -> one cycle later o_valid=1, o_rs_data=0x1234, o_rt_data=0.
REQ-038 Load writing rt=7 in ID/EX, with the next instruction having rs=7 and i_ex_ready=1 -> o_ready=0 for 1 cycle, one bubble (o_valid=0), then transfer; o_stall_cnt=1.
REQ-039 i_ex_ready=0 for 3 cycles with o_valid=1 -> outputs stable and o_ready=0; on release, the queued instruction transfers next edge.
REQ-040 i_flush=1 coinciding with a hazard and i_valid=1 -> next edge o_valid=0, o_stall_cnt unchanged.
REQ-041 Write r3=0xAAAA while decoding rs=3 in the same cycle -> with DECODE_WBYPASS_EN, o_rs_data=0xAAAA; without it, the old value; write to r0 -> reads stay 0.
REQ-042 i_instr[15:0]=0x8001 -> i_signext=1 gives o_imm=0xFFFF8001; i_signext=0 gives 0x00008001; i_nrst pulsed mid-stall -> o_valid=0, o_stall_cnt=0.
